// File: rtl/gpr_alu_exec_unit.sv
// Execute stage with a GPR bank and SGPR: one instruction per handshake, condition flags,
// and either a single-cycle or a DATA_W-cycle shift-add multiply.
module gpr_alu_exec_unit #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned NREG    = 32,
    parameter bit          MUL_SEQ = 1'b1
) (
    input  logic              clk,
    input  logic              sys_rst,
    input  logic              ir_valid,
    input  logic [31:0]       ir,
    output logic              ir_ready,
    output logic              done,
    output logic              err,
    output logic [3:0]        flags,
    output logic [DATA_W-1:0] sgpr,
    input  logic [4:0]        dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata
);
    localparam int unsigned IDX_W = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam int unsigned PW    = 2 * DATA_W;

    localparam logic [4:0] OpMovsgpr = 5'h00, OpMov  = 5'h01, OpAdd  = 5'h02, OpSub  = 5'h03;
    localparam logic [4:0] OpMul     = 5'h04, OpOr   = 5'h05, OpAnd  = 5'h06, OpXor  = 5'h07;
    localparam logic [4:0] OpXnor    = 5'h08, OpNand = 5'h09, OpNor  = 5'h0A, OpNot  = 5'h0B;

    typedef enum logic [0:0] {StIdle, StMul} state_t;
    state_t state_q, state_d;

    logic [DATA_W-1:0] gpr [NREG];
    logic [DATA_W-1:0] sgpr_q, mul_a_q;
    logic [PW-1:0]     mul_p_q;
    logic [4:0]        mul_rd_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [3:0]        flags_q;
    logic              done_q, err_q;

    logic [4:0]  oper, rdst, rsrc1, rsrc2;
    logic        imm_mode;
    logic [15:0] isrc;
    assign oper     = ir[31:27];
    assign rdst     = ir[26:22];
    assign rsrc1    = ir[21:17];
    assign imm_mode = ir[16];
    assign rsrc2    = ir[15:11];
    assign isrc     = ir[15:0];

    function automatic logic idx_ok(input logic [4:0] idx);
        return 32'(idx) < NREG;
    endfunction

    // Sign from the low half, zero over the whole product, carry/overflow from the high half.
    function automatic logic [3:0] mul_flags(input logic [PW-1:0] p);
        return {p[DATA_W-1], p == '0, |p[PW-1:DATA_W], |p[PW-1:DATA_W]};
    endfunction

    logic [DATA_W-1:0] a_val, r2_val, b_val, imm_ext;
    logic              accept, is_unary, is_binary, uses_rs1, uses_rs2, bad, start_seq;

    assign a_val     = idx_ok(rsrc1) ? gpr[rsrc1[IDX_W-1:0]] : '0;
    assign r2_val    = idx_ok(rsrc2) ? gpr[rsrc2[IDX_W-1:0]] : '0;
    assign dbg_rdata = idx_ok(dbg_raddr) ? gpr[dbg_raddr[IDX_W-1:0]] : '0;
    assign accept    = ir_valid && ir_ready;

    always_comb begin
        imm_ext        = '0;
        imm_ext[15:0]  = isrc;
        is_unary       = (oper == OpMov) || (oper == OpNot);
        is_binary      = (oper >= OpAdd) && (oper <= OpNor);
        if (imm_mode)      b_val = imm_ext;
        else if (is_unary) b_val = a_val;
        else               b_val = r2_val;
        uses_rs1  = is_binary || (is_unary && !imm_mode);
        uses_rs2  = is_binary && !imm_mode;
        bad       = (oper > OpNot) || !idx_ok(rdst) || (uses_rs1 && !idx_ok(rsrc1)) ||
                    (uses_rs2 && !idx_ok(rsrc2));
        start_seq = MUL_SEQ && accept && (oper == OpMul) && !bad;
    end

    logic [DATA_W:0]   sum, diff;
    logic [PW-1:0]     a_ext, b_ext, prod;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c, alu_o, keep_co;
    logic [3:0]        alu_flags;

    always_comb begin
        a_ext = '0;
        b_ext = '0;
        a_ext[DATA_W-1:0] = a_val;
        b_ext[DATA_W-1:0] = b_val;
        prod    = a_ext * b_ext;
        sum     = {1'b0, a_val} + {1'b0, b_val};
        diff    = {1'b0, a_val} - {1'b0, b_val};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_o   = 1'b0;
        keep_co = 1'b0;
        case (oper)
            OpMovsgpr: begin alu_res = sgpr_q; keep_co = 1'b1; end
            OpMov:     begin alu_res = b_val;  keep_co = 1'b1; end
            OpAdd: begin
                alu_res = sum[DATA_W-1:0];
                alu_c   = sum[DATA_W];
                alu_o   = (a_val[DATA_W-1] == b_val[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != a_val[DATA_W-1]);
            end
            OpSub: begin
                alu_res = diff[DATA_W-1:0];
                alu_c   = diff[DATA_W];  // borrow
                alu_o   = (a_val[DATA_W-1] != b_val[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != a_val[DATA_W-1]);
            end
            OpMul:   alu_res = prod[DATA_W-1:0];
            OpOr:    alu_res = a_val | b_val;
            OpAnd:   alu_res = a_val & b_val;
            OpXor:   alu_res = a_val ^ b_val;
            OpXnor:  alu_res = ~(a_val ^ b_val);
            OpNand:  alu_res = ~(a_val & b_val);
            OpNor:   alu_res = ~(a_val | b_val);
            OpNot:   alu_res = ~b_val;
            default: alu_res = '0;
        endcase
        if (oper == OpMul) alu_flags = mul_flags(prod);
        else alu_flags = {alu_res[DATA_W-1], alu_res == '0,
                          keep_co ? flags_q[1:0] : {alu_c, alu_o}};
    end

    logic [DATA_W:0]   mul_sum;
    logic [PW-1:0]     mul_p_next;
    logic              mul_last;

    assign mul_sum    = {1'b0, mul_p_q[PW-1:DATA_W]} + (mul_p_q[0] ? {1'b0, mul_a_q} : '0);
    assign mul_p_next = {mul_sum, mul_p_q[DATA_W-1:1]};
    assign mul_last   = (cnt_q == CNT_W'(DATA_W - 1));

    logic              wr_en, sgpr_en, flags_en, done_d, err_d;
    logic [4:0]        wr_idx;
    logic [DATA_W-1:0] wr_data, sgpr_d;
    logic [3:0]        flags_d;

    always_comb begin
        wr_en    = 1'b0;
        sgpr_en  = 1'b0;
        flags_en = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        wr_idx   = rdst;
        wr_data  = alu_res;
        sgpr_d   = prod[PW-1:DATA_W];
        flags_d  = alu_flags;
        if (state_q == StMul) begin
            if (mul_last) begin
                wr_en    = 1'b1;
                sgpr_en  = 1'b1;
                flags_en = 1'b1;
                done_d   = 1'b1;
                wr_idx   = mul_rd_q;
                wr_data  = mul_p_next[DATA_W-1:0];
                sgpr_d   = mul_p_next[PW-1:DATA_W];
                flags_d  = mul_flags(mul_p_next);
            end
        end else if (accept && !start_seq) begin
            done_d   = 1'b1;
            err_d    = bad;
            wr_en    = !bad;
            flags_en = !bad;
            sgpr_en  = !bad && (oper == OpMul);
        end
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) state_q <= StIdle;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start_seq) state_d = StMul;
            StMul:  if (mul_last)  state_d = StIdle;
        endcase
    end

    always_comb begin
        ir_ready = (state_q == StIdle);
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int unsigned i = 0; i < NREG; i++) gpr[i] <= '0;
            sgpr_q   <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            mul_a_q  <= '0;
            mul_p_q  <= '0;
            mul_rd_q <= '0;
            cnt_q    <= '0;
        end else begin
            done_q <= done_d;
            err_q  <= err_d;
            if (wr_en)    gpr[wr_idx[IDX_W-1:0]] <= wr_data;
            if (sgpr_en)  sgpr_q  <= sgpr_d;
            if (flags_en) flags_q <= flags_d;
            if (start_seq) begin
                mul_a_q  <= a_val;
                mul_p_q  <= {{DATA_W{1'b0}}, b_val};
                mul_rd_q <= rdst;
                cnt_q    <= '0;
            end else if (state_q == StMul) begin
                mul_p_q <= mul_p_next;
                cnt_q   <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign done  = done_q;
    assign err   = err_q;
    assign flags = flags_q;
    assign sgpr  = sgpr_q;
endmodule

// File: tb/tb_gpr_alu_exec_unit.sv
// Bench for gpr_alu_exec_unit: directed vector table, hand-written multi-cycle sequences and
// random instructions checked against an arithmetic reference model.
module tb_gpr_alu_exec_unit;
    localparam logic [4:0] OpMovsgpr = 5'h00, OpMov  = 5'h01, OpAdd  = 5'h02, OpSub  = 5'h03;
    localparam logic [4:0] OpMul     = 5'h04, OpOr   = 5'h05, OpAnd  = 5'h06, OpXor  = 5'h07;
    localparam logic [4:0] OpXnor    = 5'h08, OpNand = 5'h09, OpNor  = 5'h0A, OpNot  = 5'h0B;

    logic        clk = 1'b0;
    logic        sys_rst, ir_valid, ir_ready, done, err;
    logic [31:0] ir;
    logic [3:0]  flags;
    logic [15:0] sgpr, dbg_rdata;
    logic [4:0]  dbg_raddr;
    logic        s_ir_valid, s_ir_ready, s_done, s_err;
    logic [31:0] s_ir;
    logic [3:0]  s_flags;
    logic [15:0] s_sgpr, s_dbg_rdata;
    logic [4:0]  s_dbg_raddr;

    always #5 clk = ~clk;

    gpr_alu_exec_unit #(.DATA_W(16), .NREG(32), .MUL_SEQ(1'b1)) dut (
        .clk(clk), .sys_rst(sys_rst), .ir_valid(ir_valid), .ir(ir), .ir_ready(ir_ready),
        .done(done), .err(err), .flags(flags), .sgpr(sgpr), .dbg_raddr(dbg_raddr),
        .dbg_rdata(dbg_rdata)
    );

    gpr_alu_exec_unit #(.DATA_W(16), .NREG(8), .MUL_SEQ(1'b0)) u_small (
        .clk(clk), .sys_rst(sys_rst), .ir_valid(s_ir_valid), .ir(s_ir), .ir_ready(s_ir_ready),
        .done(s_done), .err(s_err), .flags(s_flags), .sgpr(s_sgpr), .dbg_raddr(s_dbg_raddr),
        .dbg_rdata(s_dbg_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [15:0] imm);
        return {op, rd, rs1, 1'b1, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
        return {op, rd, rs1, 1'b0, rs2, 11'b0};
    endfunction

    task automatic run(input logic [31:0] instr, output int cycles);
        @(negedge clk);
        ir = instr;
        ir_valid = 1'b1;
        @(posedge clk); #1;
        ir_valid = 1'b0;
        cycles = 1;
        while (!done && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic s_run(input logic [31:0] instr, output int cycles);
        @(negedge clk);
        s_ir = instr;
        s_ir_valid = 1'b1;
        @(posedge clk); #1;
        s_ir_valid = 1'b0;
        cycles = 1;
        while (!s_done && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic rd(input logic [4:0] idx, output logic [15:0] v);
        dbg_raddr = idx;
        #1;
        v = dbg_rdata;
    endtask

    task automatic s_rd(input logic [4:0] idx, output logic [15:0] v);
        s_dbg_raddr = idx;
        #1;
        v = s_dbg_rdata;
    endtask

    task automatic do_reset();
        @(negedge clk);
        sys_rst = 1'b1;
        #2;
        sys_rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Reference model: plain integer arithmetic on the architectural state.
    logic [15:0] m_gpr [32];
    logic [15:0] m_sgpr;
    logic [3:0]  m_flags;

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_gpr[i] = '0;
        m_sgpr  = '0;
        m_flags = '0;
    endtask

    task automatic model_exec(input logic [31:0] instr, output bit e_err, output int e_cyc);
        logic [4:0]  op, rdx, rs1, rs2;
        logic [15:0] a, b, r;
        int          sa, sb, s;
        longint      p;
        bit          im, c, o, z, keep;
        op  = instr[31:27];
        rdx = instr[26:22];
        rs1 = instr[21:17];
        im  = instr[16];
        rs2 = instr[15:11];
        e_err = op > OpNot;
        e_cyc = (op == OpMul) ? 17 : 1;
        if (e_err) return;
        a = m_gpr[rs1];
        if (im) b = instr[15:0];
        else if (op == OpMov || op == OpNot) b = m_gpr[rs1];
        else b = m_gpr[rs2];
        sa = (a >= 16'h8000) ? int'(a) - 65536 : int'(a);
        sb = (b >= 16'h8000) ? int'(b) - 65536 : int'(b);
        c = 0; o = 0; keep = 0; p = 0; r = '0;
        case (op)
            OpMovsgpr: begin r = m_sgpr; keep = 1; end
            OpMov:     begin r = b; keep = 1; end
            OpAdd: begin
                s = int'(a) + int'(b); r = s[15:0]; c = s > 65535;
                o = (sa + sb > 32767) || (sa + sb < -32768);
            end
            OpSub: begin
                s = int'(a) - int'(b); r = s[15:0]; c = a < b;
                o = (sa - sb > 32767) || (sa - sb < -32768);
            end
            OpMul: begin
                p = longint'(a) * longint'(b); r = p[15:0]; m_sgpr = p[31:16];
                c = p > 65535; o = c;
            end
            OpOr:    r = a | b;
            OpAnd:   r = a & b;
            OpXor:   r = a ^ b;
            OpXnor:  r = ~(a ^ b);
            OpNand:  r = ~(a & b);
            OpNor:   r = ~(a | b);
            default: r = ~b;
        endcase
        z = (op == OpMul) ? (p == 0) : (r == 0);
        m_gpr[rdx] = r;
        m_flags = {r[15], z, keep ? m_flags[1:0] : {c, o}};
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  idx;
        logic [15:0] val;
        logic [3:0]  flg;
        bit          err;
    } vec_t;

    vec_t        vecs[17];
    int          cyc, e_cyc, low, k;
    bit          e_err, saw_done;
    logic [15:0] v;
    logic [31:0] instr;
    logic [4:0]  op;
    logic [15:0] imm;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{enc_i(OpMov, 1, 0, 16'h1234),    5'd1,  16'h1234, 4'b0000, 1'b0};
        vecs[1]  = '{enc_i(OpMov, 1, 0, 16'hFFFF),    5'd1,  16'hFFFF, 4'b1000, 1'b0};
        vecs[2]  = '{enc_i(OpAdd, 2, 1, 16'h0001),    5'd2,  16'h0000, 4'b0110, 1'b0};
        vecs[3]  = '{enc_i(OpMov, 5, 0, 16'h7FFF),    5'd5,  16'h7FFF, 4'b0010, 1'b0};
        vecs[4]  = '{enc_i(OpAdd, 3, 5, 16'h0001),    5'd3,  16'h8000, 4'b1001, 1'b0};
        vecs[5]  = '{enc_r(OpSub, 6, 2, 1),           5'd6,  16'h0001, 4'b0010, 1'b0};
        vecs[6]  = '{enc_r(OpSub, 7, 3, 5),           5'd7,  16'h0001, 4'b0001, 1'b0};
        vecs[7]  = '{enc_i(OpAnd, 8, 1, 16'h0F0F),    5'd8,  16'h0F0F, 4'b0000, 1'b0};
        vecs[8]  = '{enc_r(OpNor, 9, 8, 3),           5'd9,  16'h70F0, 4'b0000, 1'b0};
        vecs[9]  = '{enc_r(OpNot, 10, 8, 0),          5'd10, 16'hF0F0, 4'b1000, 1'b0};
        vecs[10] = '{enc_i(OpXnor, 11, 1, 16'h00FF),  5'd11, 16'h00FF, 4'b0000, 1'b0};
        vecs[11] = '{enc_r(OpNand, 12, 1, 1),         5'd12, 16'h0000, 4'b0100, 1'b0};
        vecs[12] = '{enc_i(OpOr, 13, 0, 16'h0000),    5'd13, 16'h0000, 4'b0100, 1'b0};
        vecs[13] = '{enc_r(OpMov, 14, 3, 0),          5'd14, 16'h8000, 4'b1000, 1'b0};
        vecs[14] = '{enc_i(5'h1F, 15, 0, 16'h1234),   5'd15, 16'h0000, 4'b1000, 1'b1};
        vecs[15] = '{enc_r(OpXor, 15, 10, 9),         5'd15, 16'h8000, 4'b1000, 1'b0};
        vecs[16] = '{enc_i(OpMovsgpr, 16, 0, 16'h0),  5'd16, 16'h0000, 4'b0100, 1'b0};

        sys_rst = 1'b1; ir_valid = 1'b0; ir = '0; dbg_raddr = '0;
        s_ir_valid = 1'b0; s_ir = '0; s_dbg_raddr = '0;
        repeat (2) @(posedge clk);
        #1 sys_rst = 1'b0;

        check("reset_ready", ir_ready, 1);
        check("reset_flags", flags, 0);
        check("reset_done", done, 0);
        check("reset_sgpr", sgpr, 0);
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), v);
            check("reset_dbg", v, 0);
        end

        for (int i = 0; i < 17; i++) begin
            run(vecs[i].instr, cyc);
            check("vec_cycles", cyc, 1);
            check("vec_err", err, vecs[i].err);
            check("vec_flags", flags, vecs[i].flg);
            rd(vecs[i].idx, v);
            check("vec_reg", v, vecs[i].val);
        end

        // Back-to-back stream with ir_valid held high.
        do_reset();
        @(negedge clk);
        ir_valid = 1'b1;
        ir = enc_i(OpMov, 1, 0, 16'd5);
        @(posedge clk); #1;
        check("b2b_done1", done, 1);
        ir = enc_r(OpAdd, 2, 1, 1);
        @(posedge clk); #1;
        check("b2b_done2", done, 1);
        ir = enc_i(OpXor, 3, 2, 16'h000F);
        @(posedge clk); #1;
        check("b2b_done3", done, 1);
        ir_valid = 1'b0;
        @(posedge clk); #1;
        check("b2b_idle", done, 0);
        rd(5'd2, v); check("b2b_r2", v, 16'h000A);
        rd(5'd3, v); check("b2b_r3", v, 16'h0005);

        // Sequential multiply timing; a request held during MUL must be ignored.
        do_reset();
        run(enc_i(OpMov, 1, 0, 16'h1234), cyc);
        @(negedge clk);
        ir_valid = 1'b1;
        ir = enc_i(OpMul, 1, 1, 16'h0100);
        @(posedge clk); #1;
        ir = enc_i(OpMov, 7, 0, 16'hAAAA);
        cyc = 1;
        low = 0;
        while (!done && cyc < 40) begin
            if (!ir_ready) low++;
            @(posedge clk); #1;
            cyc++;
        end
        ir_valid = 1'b0;
        check("mul_latency", cyc, 17);
        check("mul_busy_cycles", low, 16);
        check("mul_err", err, 0);
        check("mul_sgpr", sgpr, 16'h0012);
        check("mul_flags", flags, 4'b0011);
        rd(5'd1, v); check("mul_lo", v, 16'h3400);
        rd(5'd7, v); check("mul_ignored_req", v, 16'h0000);
        run(enc_i(OpMovsgpr, 4, 0, 16'h0), cyc);
        rd(5'd4, v); check("movsgpr_r4", v, 16'h0012);
        check("movsgpr_flags", flags, 4'b0011);

        // Reset in the middle of a multiply.
        do_reset();
        run(enc_i(OpMov, 2, 0, 16'h0003), cyc);
        @(negedge clk);
        ir_valid = 1'b1;
        ir = enc_i(OpMul, 2, 2, 16'h0005);
        @(posedge clk); #1;
        ir_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 sys_rst = 1'b1;
        #2 sys_rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 0);
        check("abort_ready", ir_ready, 1);
        check("abort_flags", flags, 0);
        check("abort_sgpr", sgpr, 0);
        rd(5'd2, v); check("abort_r2", v, 0);
        run(enc_i(OpMov, 2, 0, 16'h0042), cyc);
        check("abort_next_cycles", cyc, 1);
        rd(5'd2, v); check("abort_next_r2", v, 16'h0042);

        // NREG = 8, single-cycle multiply.
        s_run(enc_i(OpMov, 1, 0, 16'h80AA), cyc);
        check("s_mov_flags", s_flags, 4'b1000);
        s_run(enc_i(OpMov, 9, 0, 16'h1111), cyc);
        check("s_bad_rdst_cycles", cyc, 1);
        check("s_bad_rdst_err", s_err, 1);
        check("s_bad_rdst_flags", s_flags, 4'b1000);
        s_rd(5'd9, v); check("s_dbg_out_of_range", v, 0);
        s_run(enc_r(OpAdd, 2, 1, 12), cyc);
        check("s_bad_rsrc2_err", s_err, 1);
        s_rd(5'd2, v); check("s_bad_rsrc2_r2", v, 0);
        s_run(enc_i(OpMul, 3, 1, 16'h0100), cyc);
        check("s_mul_cycles", cyc, 1);
        check("s_mul_err", s_err, 0);
        check("s_mul_sgpr", s_sgpr, 16'h0080);
        check("s_mul_flags", s_flags, 4'b1011);
        s_rd(5'd3, v); check("s_mul_lo", v, 16'hAA00);

        // Random instructions against the reference model.
        do_reset();
        model_clear();
        for (int n = 0; n < 150; n++) begin
            k = $urandom_range(0, 13);
            op = (k == 13) ? 5'($urandom_range(12, 31)) : 5'(k);
            case ($urandom_range(0, 4))
                0:       imm = 16'h0000;
                1:       imm = 16'hFFFF;
                2:       imm = 16'h7FFF;
                3:       imm = 16'h8000;
                default: imm = 16'($urandom);
            endcase
            instr = {op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                     1'($urandom_range(0, 1)), imm};
            model_exec(instr, e_err, e_cyc);
            run(instr, cyc);
            check("rand_cycles", cyc, e_cyc);
            check("rand_err", err, e_err);
            check("rand_flags", flags, m_flags);
            check("rand_sgpr", sgpr, m_sgpr);
            rd(instr[26:22], v);
            check("rand_reg", v, m_gpr[instr[26:22]]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
